// File: rtl/sdp_ram_stream_reader.sv
// rtl/sdp_ram_stream_reader.sv - burst reader turning a registered-output RAM read port into a valid/ready stream
module sdp_ram_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH:0]   cmd_count,
  output logic                  renable,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH:0]   remaining;
  logic [ADDR_WIDTH:0]   tosend;
  logic                  inflight;

  logic [DATA_WIDTH-1:0] fifo [3];
  logic [1:0]            wr_ptr;
  logic [1:0]            rd_ptr;
  logic [1:0]            occupancy;

  logic                  push;
  logic                  pop;
  logic [2:0]            outstanding;

  function automatic logic [1:0] ptr_next(input logic [1:0] ptr);
    return (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
  endfunction

  // Words held in the FIFO plus the one the RAM is fetching; capped at the FIFO depth.
  assign outstanding = {1'b0, occupancy} + {2'b00, inflight};

  assign renable   = (state == READ) && (remaining != '0) && (outstanding < 3'd3);
  assign raddr     = addr;
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  assign out_valid = (occupancy != 2'd0);
  assign out_data  = out_valid ? fifo[rd_ptr] : '0;
  assign out_last  = out_valid && (tosend == {{ADDR_WIDTH{1'b0}}, 1'b1});

  assign push = inflight;
  assign pop  = out_valid && out_ready;

  // Storage carries no reset; the pointers and occupancy decide what is live.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo[wr_ptr] <= rdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      tosend    <= '0;
      inflight  <= 1'b0;
      wr_ptr    <= 2'd0;
      rd_ptr    <= 2'd0;
      occupancy <= 2'd0;
    end else begin
      inflight <= renable;

      if (push) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end

      case ({push, pop})
        2'b10:   occupancy <= occupancy + 2'd1;
        2'b01:   occupancy <= occupancy - 2'd1;
        default: occupancy <= occupancy;
      endcase

      case (state)
        IDLE: begin
          if (cmd_valid && (cmd_count != '0)) begin
            state     <= READ;
            addr      <= cmd_addr;
            remaining <= cmd_count;
            tosend    <= cmd_count;
          end
        end
        READ: begin
          if (renable) begin
            addr      <= addr + 1'b1;
            remaining <= remaining - 1'b1;
          end
          if (pop) begin
            tosend <= tosend - 1'b1;
            if (out_last) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdp_ram_stream_reader.sv
// tb/tb_sdp_ram_stream_reader.sv - scoreboard bench for sdp_ram_stream_reader with a behavioural RAM
module tb_sdp_ram_stream_reader;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clock;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [AW:0]   cmd_count;
  logic          renable;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;

  logic [DW-1:0] ram_mem [DEPTH];

  int vectors     = 0;
  int miscompares = 0;

  logic [DW-1:0] exp_data [$];
  bit            exp_last [$];
  int            exp_addr [$];

  int       ready_mode = 0;
  int       issued     = 0;
  int       popped     = 0;
  bit       stalled    = 0;
  bit       last_seen  = 0;
  logic [DW-1:0] stall_data;
  logic          stall_last;

  sdp_ram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_count (cmd_count),
    .renable   (renable),
    .raddr     (raddr),
    .rdata     (rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Registered-output RAM read port; rdata holds when renable is low.
  always @(posedge clock) begin
    if (renable) rdata <= ram_mem[raddr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    vectors++;
    miscompares++;
    $display("FAIL %s: %s at %0t", name, what, $time);
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clock);
      #2;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: every DUT output event is compared against the queued expectations.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (last_seen) begin
          check("busy_after_last", {31'b0, busy}, 0);
          check("cmd_ready_after_last", {31'b0, cmd_ready}, 1);
          last_seen = 0;
        end
        if (stalled) begin
          check("stall_valid", {31'b0, out_valid}, 1);
          check("stall_data", {24'b0, out_data}, {24'b0, stall_data});
          check("stall_last", {31'b0, out_last}, {31'b0, stall_last});
          stalled = 0;
        end
        if (renable) begin
          if (exp_addr.size() == 0) fail_now("unexpected_renable", "read issued with no reads pending");
          else check("raddr", {28'b0, raddr}, exp_addr.pop_front());
          check("outstanding_le_3", (issued + 1 - popped <= 3) ? 1 : 0, 1);
          issued++;
        end
        if (out_valid) check("busy_with_valid", {31'b0, busy}, 1);
        if (out_valid && out_ready) begin
          popped++;
          if (exp_data.size() == 0) begin
            fail_now("unexpected_word", $sformatf("got 0x%0h expected no word", out_data));
          end else begin
            check("out_data", {24'b0, out_data}, {24'b0, exp_data.pop_front()});
            check("out_last", {31'b0, out_last}, {31'b0, exp_last.pop_front()});
            if (out_last) last_seen = 1;
          end
        end else if (out_valid) begin
          stalled    = 1;
          stall_data = out_data;
          stall_last = out_last;
        end
      end
    end
  end

  // Called at posedge+#1; returns at posedge+#1 after the accepting edge.
  task automatic send_cmd(input int a, input int c, output int waited);
    cmd_valid = 1'b1;
    cmd_addr  = AW'(a);
    cmd_count = (AW+1)'(c);
    waited    = 0;
    @(negedge clock);
    while (!cmd_ready && waited < 2000) begin
      waited++;
      @(negedge clock);
    end
    if (!cmd_ready) fail_now("cmd_accept_timeout", "cmd_ready never rose within 2000 cycles");
    for (int i = 0; i < c; i++) begin
      exp_addr.push_back((a + i) % DEPTH);
      exp_data.push_back(ram_mem[(a + i) % DEPTH]);
      exp_last.push_back(i == c - 1);
    end
    @(posedge clock);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while ((busy || exp_data.size() != 0) && n < 3000);
    if (busy || exp_data.size() != 0)
      fail_now("idle_timeout", $sformatf("busy=%0d pending=%0d after 3000 cycles", busy, exp_data.size()));
    check("leftover_reads", exp_addr.size(), 0);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int n;
    int p0;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_count = '0;
    for (int i = 0; i < DEPTH; i++) ram_mem[i] = DW'(8'h10 + i);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    @(negedge clock);
    check("rst_out_valid", {31'b0, out_valid}, 0);
    check("rst_out_last", {31'b0, out_last}, 0);
    check("rst_renable", {31'b0, renable}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_cmd_ready", {31'b0, cmd_ready}, 1);
    check("rst_raddr", {28'b0, raddr}, 0);
    check("rst_out_data", {24'b0, out_data}, 0);
    @(posedge clock);
    #1;

    // Basic burst with latency and back-to-back words.
    ready_mode = 0;
    send_cmd(3, 4, w);
    @(negedge clock);
    check("t1_renable_k", {31'b0, renable}, 1);
    check("t1_valid_k", {31'b0, out_valid}, 0);
    @(negedge clock);
    check("t1_valid_k1", {31'b0, out_valid}, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("t1_valid_stream", {31'b0, out_valid}, 1);
      check("t1_word", {24'b0, out_data}, 32'h13 + i);
    end
    wait_idle();

    // Address wrap.
    send_cmd(14, 4, w);
    wait_idle();

    // Backpressure.
    ready_mode = 1;
    @(posedge clock);
    #1;
    send_cmd(0, 16, w);
    n = 0;
    repeat (6) begin
      @(negedge clock);
      if (renable) n++;
    end
    check("t3_reads_before_pop", n, 3);
    ready_mode = 2;
    wait_idle();
    ready_mode = 0;
    @(posedge clock);
    #1;

    // Zero count, back-to-back acceptance.
    send_cmd(0, 0, w);
    send_cmd(2, 0, w);
    check("t4_second_accept_wait", w, 0);
    repeat (3) begin
      @(negedge clock);
      check("t4_renable", {31'b0, renable}, 0);
      check("t4_valid", {31'b0, out_valid}, 0);
      check("t4_busy", {31'b0, busy}, 0);
    end
    @(posedge clock);
    #1;
    send_cmd(7, 1, w);
    check("t4_after_zero_wait", w, 0);
    wait_idle();

    // Over-depth count.
    send_cmd(0, 20, w);
    wait_idle();

    // Reset mid-burst.
    p0 = popped;
    send_cmd(0, 8, w);
    n = 0;
    while (popped - p0 < 2 && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (popped - p0 < 2) fail_now("t6_words_timeout", "fewer than 2 words within 100 cycles");
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    exp_data.delete();
    exp_last.delete();
    exp_addr.delete();
    issued    = 0;
    popped    = 0;
    stalled   = 0;
    last_seen = 0;
    @(negedge clock);
    check("t6_valid", {31'b0, out_valid}, 0);
    check("t6_busy", {31'b0, busy}, 0);
    check("t6_cmd_ready", {31'b0, cmd_ready}, 1);
    check("t6_renable", {31'b0, renable}, 0);
    @(posedge clock);
    #1;
    send_cmd(5, 2, w);
    wait_idle();

    // Randomized commands over random RAM contents with random backpressure.
    for (int i = 0; i < DEPTH; i++) ram_mem[i] = DW'($urandom);
    ready_mode = 2;
    for (int k = 0; k < 12; k++) begin
      send_cmd(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 31)), w);
      repeat ($urandom_range(0, 3)) @(posedge clock);
      #1;
    end
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
